// File: rtl/remote_rom_server.sv
// Far-end responder for the byte-serial remote ROM link: collects an 8-byte LE address,
// reads one 64-bit ROM word (or returns ERR_DATA off-window) and streams it back LSB first.
module remote_rom_server #(
  parameter logic [63:0] ROM_BASE = 64'h0000_0000_0000_1000,
  parameter int unsigned ROM_AW   = 10,
  parameter logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              empty,
  output logic              rd_en,
  input  logic [7:0]        dout,
  input  logic              full,
  output logic              wr_en,
  output logic [7:0]        din,
  output logic              mem_en,
  output logic [ROM_AW-1:0] mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic              busy,
  output logic [15:0]       req_count,
  output logic [15:0]       err_count
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BYTES   = 8;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    req_cnt;
  logic [CNT_W-1:0]    rx_cnt;
  logic [CNT_W-1:0]    tx_cnt;
  logic                rd_en_q;
  logic [DATA_W-1:0]   addr_buf;
  logic [DATA_W-1:0]   data_buf;
  logic [DATA_W-1:0]   off;
  logic                in_window;

  // Window decode and the FIFO/ROM strobes, all decoded from the current state.
  always_comb begin
    off       = addr_buf - ROM_BASE;
    in_window = (addr_buf >= ROM_BASE) && ((off >> 3) < (64'd1 << ROM_AW));
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    din       = 8'd0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    busy      = (state != S_ADDR) || (req_cnt != CNT_W'(0));
    case (state)
      S_ADDR:  rd_en = ~empty && (req_cnt != CNT_W'(BYTES));
      S_FETCH: begin
        if (in_window) begin
          mem_en   = 1'b1;
          mem_addr = off[ROM_AW+2:3];
        end
      end
      S_SEND: begin
        wr_en = ~full;
        din   = data_buf[7:0];
      end
      default: ;
    endcase
  end

  // Request sequencing; the 8th address capture moves straight to FETCH on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ADDR;
      req_cnt   <= '0;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      rd_en_q   <= 1'b0;
      addr_buf  <= '0;
      data_buf  <= '0;
      req_count <= '0;
      err_count <= '0;
    end else begin
      rd_en_q <= rd_en;
      case (state)
        S_ADDR: begin
          if (rd_en) req_cnt <= req_cnt + CNT_W'(1);
          if (rd_en_q) begin
            addr_buf <= {dout, addr_buf[63:8]};
            if (rx_cnt == CNT_W'(BYTES - 1)) begin
              rx_cnt  <= '0;
              req_cnt <= '0;
              state   <= S_FETCH;
            end else begin
              rx_cnt <= rx_cnt + CNT_W'(1);
            end
          end
        end
        S_FETCH: begin
          if (in_window) begin
            state <= S_WAIT;
          end else begin
            data_buf <= ERR_DATA;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            state <= S_SEND;
          end
        end
        S_WAIT: begin
          data_buf <= mem_rdata;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (wr_en) begin
            data_buf <= data_buf >> 8;
            if (tx_cnt == CNT_W'(BYTES - 1)) begin
              tx_cnt    <= '0;
              req_count <= req_count + 16'd1;
              state     <= S_ADDR;
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_rom_server.sv
// Bench for remote_rom_server: FIFO and ROM models around the DUT, directed table plus
// random traffic checked against a word-level model of the ROM window.
module tb_remote_rom_server;

  localparam logic [63:0] ROM_BASE  = 64'h0000_0000_0000_1000;
  localparam int unsigned ROM_AW    = 10;
  localparam int          ROM_WORDS = 1 << ROM_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              empty = 1'b1;
  logic              full = 1'b0;
  logic              rd_en, wr_en, mem_en, busy;
  logic [7:0]        dout = 8'd0;
  logic [7:0]        din;
  logic [ROM_AW-1:0] mem_addr;
  logic [63:0]       mem_rdata = 64'd0;
  logic [15:0]       req_count, err_count;

  remote_rom_server #(.ROM_BASE(ROM_BASE), .ROM_AW(ROM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rd_en(rd_en), .dout(dout),
    .full(full), .wr_en(wr_en), .din(din), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .req_count(req_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [63:0]       rom [ROM_WORDS];
  logic [7:0]        cmd_q[$];
  logic [7:0]        rsp_q[$];
  int                rd_cyc[$];
  int                wr_cyc[$];
  int                cyc = 0;
  int                mem_pulses = 0;
  logic [ROM_AW-1:0] last_mem_addr = '0;
  bit                pop_pending = 0, push_pending = 0, mem_pending = 0;
  logic [7:0]        din_s = 8'd0;
  logic [ROM_AW-1:0] addr_s = '0;
  int                gap_left = 0;
  bit                gaps_on = 0, full_rand = 0;
  int                stall_from = -100;
  int                wr_while_full = 0, pop_underflow = 0;
  int                n_checks = 0, n_fail = 0;
  int                rd0, wr0, mp0;

  // Observe DUT strobes mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    pop_pending  = rd_en;
    push_pending = wr_en;
    mem_pending  = mem_en;
    din_s        = din;
    addr_s       = mem_addr;
    if (rd_en) rd_cyc.push_back(cyc);
    if (wr_en) wr_cyc.push_back(cyc);
    if (wr_en && full) wr_while_full++;
    if (mem_en) begin
      mem_pulses++;
      last_mem_addr = mem_addr;
    end
  end

  // FIFO pair and synchronous ROM behaviour, applied just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_pending) begin
      if (cmd_q.size() == 0) pop_underflow++;
      else dout = cmd_q.pop_front();
      if (gaps_on) gap_left = $urandom_range(0, 5);
    end
    if (push_pending) rsp_q.push_back(din_s);
    mem_rdata = mem_pending ? rom[addr_s] : 64'hA5A5_5A5A_DEAD_BEEF;
    empty = !rst_n || (cmd_q.size() == 0) || (gap_left > 0);
    if (gap_left > 0) gap_left--;
    if (cyc >= stall_from && cyc < stall_from + 7) full = 1'b1;
    else full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0] idx;
    if (a < ROM_BASE) return '1;
    idx = (a - ROM_BASE) / 64'd8;
    if (idx >= 64'(ROM_WORDS)) return '1;
    return rom[idx[ROM_AW-1:0]];
  endfunction

  function automatic logic [63:0] outs();
    return 64'({rd_en, wr_en, mem_en, busy, din, mem_addr, req_count, err_count});
  endfunction

  task automatic push_addr(input logic [63:0] a);
    for (int i = 0; i < 8; i++) cmd_q.push_back(a[8*i +: 8]);
  endtask

  task automatic mark();
    rd0 = rd_cyc.size();
    wr0 = wr_cyc.size();
    mp0 = mem_pulses;
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int t = 0;
    while (rsp_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (rsp_q.size() >= n);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d bytes, need %0d", rsp_q.size(), n);
    end
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    int t = 0;
    while (rd_cyc.size() - rd0 < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (rd_cyc.size() - rd0 >= n);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL pop_timeout: got %0d pops, need %0d", rd_cyc.size() - rd0, n);
    end
  endtask

  function automatic logic [63:0] pop_word();
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = rsp_q.pop_front();
    return w;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_outs_in_reset"}, outs(), 64'd0);
    cmd_q.delete();
    rsp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_outs_after_reset"}, outs(), 64'd0);
  endtask

  task automatic clean_request(input string tag, input logic [63:0] a, input logic [15:0] exp_req);
    bit ok;
    mark();
    push_addr(a);
    wait_rsp(8, 200, ok);
    if (ok) begin
      check({tag, "_data"}, pop_word(), ref_word(a));
      check({tag, "_req_count"}, 64'(req_count), 64'(exp_req));
    end
  endtask

  typedef struct {
    logic [63:0]       addr;
    logic [63:0]       exp_word;
    bit                exp_mem;
    logic [ROM_AW-1:0] exp_maddr;
    logic [15:0]       exp_req;
    logic [15:0]       exp_err;
  } vec_t;

  vec_t        tbl[7];
  logic [63:0] exp_q[$];

  initial begin
    bit          ok;
    logic [63:0] a;
    logic [63:0] w;
    int          n_oow;
    logic [7:0]  exp_bytes[8];

    for (int i = 0; i < ROM_WORDS; i++) rom[i] = {$urandom, $urandom};
    rom[0]    = 64'h0123_4567_89AB_CDEF;
    rom[1]    = 64'hFEDC_BA98_7654_3210;
    rom[1023] = 64'h1122_3344_5566_7788;

    tbl[0] = '{64'h0000_0000_0000_0FF8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'd0,    16'd1, 16'd1};
    tbl[1] = '{64'h0000_0000_0000_3000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'd0,    16'd2, 16'd2};
    tbl[2] = '{64'h0000_0000_0000_1000, 64'h0123_4567_89AB_CDEF, 1'b1, 10'd0,    16'd3, 16'd2};
    tbl[3] = '{64'h0000_0000_0000_100D, 64'hFEDC_BA98_7654_3210, 1'b1, 10'd1,    16'd4, 16'd2};
    tbl[4] = '{64'h0000_0000_0000_2FFF, 64'h1122_3344_5566_7788, 1'b1, 10'd1023, 16'd5, 16'd2};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'd0,    16'd6, 16'd3};
    tbl[6] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'd0,    16'd7, 16'd4};

    do_reset("init");

    // Directed single requests with no flow-control pressure.
    for (int i = 0; i < 7; i++) begin
      mark();
      push_addr(tbl[i].addr);
      wait_rsp(8, 100, ok);
      if (ok) begin
        check($sformatf("tbl%0d_data", i), pop_word(), tbl[i].exp_word);
        check($sformatf("tbl%0d_mem_pulses", i), 64'(mem_pulses - mp0), 64'(tbl[i].exp_mem));
        if (tbl[i].exp_mem)
          check($sformatf("tbl%0d_mem_addr", i), 64'(last_mem_addr), 64'(tbl[i].exp_maddr));
        check($sformatf("tbl%0d_pops", i), 64'(rd_cyc.size() - rd0), 64'd8);
        check($sformatf("tbl%0d_first_wr_lat", i), 64'(wr_cyc[wr0] - rd_cyc[rd0]),
              tbl[i].exp_mem ? 64'd11 : 64'd10);
        check($sformatf("tbl%0d_last_wr_lat", i), 64'(wr_cyc[wr0+7] - rd_cyc[rd0]),
              tbl[i].exp_mem ? 64'd18 : 64'd17);
        check($sformatf("tbl%0d_req_count", i), 64'(req_count), 64'(tbl[i].exp_req));
        check($sformatf("tbl%0d_err_count", i), 64'(err_count), 64'(tbl[i].exp_err));
        check($sformatf("tbl%0d_busy_idle", i), 64'(busy), 64'd0);
      end
    end

    // Command gaps plus a 7-cycle full stall in the middle of the send phase.
    gaps_on = 1;
    mark();
    a = ROM_BASE + 64'($urandom_range(0, 8 * ROM_WORDS - 1));
    w = ref_word(a);
    for (int i = 0; i < 8; i++) exp_bytes[i] = w[8*i +: 8];
    push_addr(a);
    wait_rsp(3, 400, ok);
    if (ok) begin
      stall_from = cyc + 1;
      repeat (7) begin
        @(negedge clk);
        check("stall_no_wr_en", 64'(wr_en), 64'd0);
        if (rsp_q.size() < 8) check("stall_din_held", 64'(din), 64'(exp_bytes[rsp_q.size()]));
      end
      wait_rsp(8, 100, ok);
      if (ok) begin
        check("flow_data", pop_word(), w);
        check("flow_pops", 64'(rd_cyc.size() - rd0), 64'd8);
      end
    end
    gaps_on = 0;

    // Reset after three address pops, then a clean request.
    do_reset("pre_mid_addr");
    mark();
    push_addr(64'h1008);
    wait_pops(3, 50, ok);
    do_reset("mid_addr");
    clean_request("after_mid_addr", 64'h1010, 16'd1);

    // Reset after four response pushes, then a clean request.
    do_reset("pre_mid_send");
    mark();
    push_addr(64'h1018);
    wait_rsp(4, 100, ok);
    do_reset("mid_send");
    clean_request("after_mid_send", 64'h1020, 16'd1);

    // 100 queued in-window requests, no stalls: strictly periodic 19-cycle service.
    do_reset("pre_b2b");
    mark();
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      a = ROM_BASE + 64'($urandom_range(0, 8 * ROM_WORDS - 1));
      exp_q.push_back(ref_word(a));
      push_addr(a);
    end
    wait_rsp(800, 4000, ok);
    if (ok) begin
      for (int i = 0; i < 100; i++) check($sformatf("b2b_data%0d", i), pop_word(), exp_q[i]);
      check("b2b_req_count", 64'(req_count), 64'd100);
      check("b2b_pops", 64'(rd_cyc.size() - rd0), 64'd800);
      check("b2b_next_pop_after_push", 64'(rd_cyc[rd0+8]), 64'(wr_cyc[wr0+7] + 1));
      check("b2b_total_span", 64'(wr_cyc[wr0+799] - rd_cyc[rd0]), 64'(100 * 19 - 1));
    end

    // Mixed in/out-of-window traffic under random gaps and a toggling full flag.
    gaps_on = 1;
    full_rand = 1;
    mark();
    exp_q.delete();
    n_oow = 0;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 7) == 0) a = {32'hFFFF_FFFF, $urandom};
      else a = 64'($urandom_range(0, 32'h4000));
      if (ref_word(a) == '1 && (a < ROM_BASE || a >= ROM_BASE + 64'(8 * ROM_WORDS))) n_oow++;
      exp_q.push_back(ref_word(a));
      push_addr(a);
    end
    wait_rsp(160, 4000, ok);
    if (ok) begin
      for (int i = 0; i < 20; i++) check($sformatf("mix_data%0d", i), pop_word(), exp_q[i]);
      check("mix_req_count", 64'(req_count), 64'd120);
      check("mix_err_count", 64'(err_count), 64'(n_oow));
      check("mix_pops", 64'(rd_cyc.size() - rd0), 64'd160);
    end
    gaps_on = 0;
    full_rand = 0;
    repeat (5) @(negedge clk);

    check("no_wr_en_while_full", 64'(wr_while_full), 64'd0);
    check("no_pop_on_empty", 64'(pop_underflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
